// File: rtl/axil_regfile_pkg.sv
// Shared response codes and handshake state encodings for the AXI4-Lite register file.
package axil_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage with byte-strobe merge; read-only slots pass reg_in through.
module axil_reg_bank #(
    parameter int                  DATA_WIDTH = 32,
    parameter int                  NUM_REGS   = 16,
    parameter int                  IDX_WIDTH  = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [IDX_WIDTH-1:0]           wr_idx,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic [IDX_WIDTH-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int SPAN = 2**IDX_WIDTH;

    // Full address span is populated so out-of-range reads decode to zero.
    logic [DATA_WIDTH-1:0] value [SPAN];
    logic [NUM_REGS-1:0]   unused_in;

    for (genvar gi = 0; gi < SPAN; gi++) begin : g_reg
        if (gi >= NUM_REGS) begin : g_absent
            assign value[gi] = '0;
        end else if (RO_MASK[gi]) begin : g_ro
            assign value[gi]                              = reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH]   = '0;
            assign wr_pulse[gi]                           = 1'b0;
            assign unused_in[gi]                          = 1'b0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] q_reg;
            logic                  pulse_reg;
            logic                  hit;

            assign hit = wr_en && (wr_idx == IDX_WIDTH'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg     <= DATA_WIDTH'(gi);
                    pulse_reg <= 1'b0;
                end else begin
                    pulse_reg <= hit;
                    if (hit) begin
                        for (int b = 0; b < DATA_WIDTH/8; b++) begin
                            if (wr_strb[b]) begin
                                q_reg[b*8 +: 8] <= wr_data[b*8 +: 8];
                            end
                        end
                    end
                end
            end

            assign value[gi]                            = q_reg;
            assign reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = q_reg;
            assign wr_pulse[gi]                         = pulse_reg;
            assign unused_in[gi]                        = ^reg_in[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign rd_data = value[rd_idx];

endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite slave register file: independent AW/W capture, single-beat write response,
// latency-1 reads, read-only registers sourced from hardware inputs.
module axil_regfile
    import axil_regfile_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
    input  logic                                   s_aclk,
    input  logic                                   s_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                             s_awprot,
    input  logic                                   s_awvalid,
    output logic                                   s_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          s_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                                   s_wvalid,
    output logic                                   s_wready,
    output logic [1:0]                             s_bresp,
    output logic                                   s_bvalid,
    input  logic                                   s_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                             s_arprot,
    input  logic                                   s_arvalid,
    output logic                                   s_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                             s_rresp,
    output logic                                   s_rvalid,
    input  logic                                   s_rready,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int OFFS  = $clog2(DW/8);
    localparam int IDX_W = AW - OFFS;
    localparam int SPAN  = 2**IDX_W;

    wr_state_t           wr_state_reg, wr_state_next;
    rd_state_t           rd_state_reg, rd_state_next;
    logic                live_reg;
    logic                aw_held_reg, w_held_reg;
    logic [IDX_W-1:0]    aw_idx_reg;
    logic [DW-1:0]       w_data_reg;
    logic [DW/8-1:0]     w_strb_reg;
    logic [1:0]          bresp_reg, rresp_reg;
    logic [DW-1:0]       rdata_reg;
    logic [SPAN-1:0]     writable, readable;
    logic [DW-1:0]       bank_rd_data;
    logic [IDX_W-1:0]    rd_idx;
    logic                commit, ar_fire;
    logic                unused_bits;

    for (genvar gi = 0; gi < SPAN; gi++) begin : g_decode
        if (gi < NUM_REGS) begin : g_present
            assign readable[gi] = 1'b1;
            assign writable[gi] = !RO_MASK[gi];
        end else begin : g_absent
            assign readable[gi] = 1'b0;
            assign writable[gi] = 1'b0;
        end
    end

    // live_reg keeps every ready low during reset and raises them on the first edge after release.
    assign s_awready = live_reg && (wr_state_reg == W_IDLE) && !aw_held_reg;
    assign s_wready  = live_reg && (wr_state_reg == W_IDLE) && !w_held_reg;
    assign s_bvalid  = (wr_state_reg == W_RESP);
    assign s_bresp   = bresp_reg;
    assign commit    = (wr_state_reg == W_IDLE) && aw_held_reg && w_held_reg;

    assign s_arready = live_reg && (rd_state_reg == R_IDLE);
    assign s_rvalid  = (rd_state_reg == R_DATA);
    assign s_rdata   = rdata_reg;
    assign s_rresp   = rresp_reg;
    assign ar_fire   = s_arready && s_arvalid;
    assign rd_idx    = s_araddr[AW-1:OFFS];

    assign unused_bits = ^{s_awprot, s_arprot, s_awaddr[OFFS-1:0], s_araddr[OFFS-1:0]};

    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            W_IDLE:  if (commit)   wr_state_next = W_RESP;
            W_RESP:  if (s_bready) wr_state_next = W_IDLE;
            default: wr_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_next = rd_state_reg;
        case (rd_state_reg)
            R_IDLE:  if (ar_fire)  rd_state_next = R_DATA;
            R_DATA:  if (s_rready) rd_state_next = R_IDLE;
            default: rd_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            wr_state_reg <= W_IDLE;
            rd_state_reg <= R_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
            rd_state_reg <= rd_state_next;
        end
    end

    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            live_reg    <= 1'b0;
            aw_held_reg <= 1'b0;
            aw_idx_reg  <= '0;
            w_held_reg  <= 1'b0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bresp_reg   <= RESP_OKAY;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
        end else begin
            live_reg <= 1'b1;
            if (s_awready && s_awvalid) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_awaddr[AW-1:OFFS];
            end
            if (s_wready && s_wvalid) begin
                w_held_reg <= 1'b1;
                w_data_reg <= s_wdata;
                w_strb_reg <= s_wstrb;
            end
            if (commit) begin
                bresp_reg <= writable[aw_idx_reg] ? RESP_OKAY : RESP_SLVERR;
            end
            if (s_bvalid && s_bready) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
            // Bank read is combinational on current storage, so a same-edge commit is not visible.
            if (ar_fire) begin
                rdata_reg <= bank_rd_data;
                rresp_reg <= readable[rd_idx] ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axil_reg_bank #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NUM_REGS),
        .IDX_WIDTH  (IDX_W),
        .RO_MASK    (RO_MASK)
    ) u_bank (
        .clk      (s_aclk),
        .rst_n    (s_aresetn),
        .wr_en    (commit && writable[aw_idx_reg]),
        .wr_idx   (aw_idx_reg),
        .wr_data  (w_data_reg),
        .wr_strb  (w_strb_reg),
        .rd_idx   (rd_idx),
        .rd_data  (bank_rd_data),
        .reg_in   (reg_in),
        .reg_out  (reg_out),
        .wr_pulse (wr_pulse)
    );

endmodule

// File: tb/tb_axil_regfile.sv
// Directed bench for axil_regfile: 4 registers, register 0 read-only, 32-bit data, 6-bit address.
module tb_axil_regfile;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic          s_aclk = 1'b0;
    logic          s_aresetn = 1'b0;
    logic [5:0]    s_awaddr = '0;
    logic [2:0]    s_awprot = '0;
    logic          s_awvalid = 1'b0;
    logic          s_awready;
    logic [31:0]   s_wdata = '0;
    logic [3:0]    s_wstrb = '0;
    logic          s_wvalid = 1'b0;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready = 1'b0;
    logic [5:0]    s_araddr = '0;
    logic [2:0]    s_arprot = '0;
    logic          s_arvalid = 1'b0;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready = 1'b0;
    logic [127:0]  reg_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hCAFE_0000};
    logic [127:0]  reg_out;
    logic [3:0]    wr_pulse;

    int vectors = 0;
    int miscompares = 0;

    always #5 s_aclk = ~s_aclk;

    axil_regfile #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (6),
        .NUM_REGS           (4),
        .RO_MASK            (4'b0001)
    ) dut (
        .s_aclk    (s_aclk),
        .s_aresetn (s_aresetn),
        .s_awaddr  (s_awaddr),
        .s_awprot  (s_awprot),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arprot  (s_arprot),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready),
        .reg_in    (reg_in),
        .reg_out   (reg_out),
        .wr_pulse  (wr_pulse)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_slice(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    // w_lead = 0 presents AW and W together; otherwise W leads AW by w_lead cycles.
    task automatic do_write(input string tag, input logic [5:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead,
                            input logic [1:0] exp_resp, input logic [3:0] exp_pulse);
        check({tag, "_wready"}, s_wready, 1'b1);
        if (w_lead > 0) begin
            s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb;
            @(negedge s_aclk);
            s_wvalid = 1'b0;
            check({tag, "_wready_held"}, s_wready, 1'b0);
            repeat (w_lead - 1) @(negedge s_aclk);
            check({tag, "_awready"}, s_awready, 1'b1);
            s_awvalid = 1'b1; s_awaddr = addr;
            @(negedge s_aclk);
            s_awvalid = 1'b0;
        end else begin
            check({tag, "_awready"}, s_awready, 1'b1);
            s_awvalid = 1'b1; s_awaddr = addr;
            s_wvalid  = 1'b1; s_wdata = data; s_wstrb = strb;
            @(negedge s_aclk);
            s_awvalid = 1'b0; s_wvalid = 1'b0;
        end
        check({tag, "_awready_full"}, s_awready, 1'b0);
        check({tag, "_bvalid_early"}, s_bvalid, 1'b0);
        @(negedge s_aclk);
        check({tag, "_bvalid"}, s_bvalid, 1'b1);
        check({tag, "_bresp"}, s_bresp, exp_resp);
        check({tag, "_wr_pulse"}, wr_pulse, exp_pulse);
        s_bready = 1'b1;
        @(negedge s_aclk);
        s_bready = 1'b0;
        check({tag, "_bvalid_done"}, s_bvalid, 1'b0);
        check({tag, "_wr_pulse_done"}, wr_pulse, 4'b0000);
        $display("write %s addr=%02h data=%08h strb=%h bresp=%0d", tag, addr, data, strb, s_bresp);
    endtask

    task automatic do_read(input string tag, input logic [5:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        check({tag, "_arready"}, s_arready, 1'b1);
        s_arvalid = 1'b1; s_araddr = addr;
        @(negedge s_aclk);
        s_arvalid = 1'b0;
        check({tag, "_rvalid"}, s_rvalid, 1'b1);
        check({tag, "_rdata"}, s_rdata, exp_data);
        check({tag, "_rresp"}, s_rresp, exp_resp);
        check({tag, "_arready_busy"}, s_arready, 1'b0);
        s_rready = 1'b1;
        @(negedge s_aclk);
        s_rready = 1'b0;
        check({tag, "_rvalid_done"}, s_rvalid, 1'b0);
        $display("read  %s addr=%02h rdata=%08h rresp=%0d", tag, addr, exp_data, exp_resp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, s_awready, 1'b0);
        check({tag, "_wready"}, s_wready, 1'b0);
        check({tag, "_arready"}, s_arready, 1'b0);
        check({tag, "_bvalid"}, s_bvalid, 1'b0);
        check({tag, "_rvalid"}, s_rvalid, 1'b0);
        check({tag, "_bresp"}, s_bresp, 2'b00);
        check({tag, "_rresp"}, s_rresp, 2'b00);
        check({tag, "_rdata"}, s_rdata, 32'h0);
        check({tag, "_wr_pulse"}, wr_pulse, 4'b0000);
        check({tag, "_reg_out"}, reg_out, {32'h3, 32'h2, 32'h1, 32'h0});
    endtask

    initial begin
        @(negedge s_aclk);
        @(negedge s_aclk);
        check_reset_outputs("reset");
        s_aresetn = 1'b1;
        #1;
        check("release_awready", s_awready, 1'b0);
        @(negedge s_aclk);
        check("live_awready", s_awready, 1'b1);
        check("live_arready", s_arready, 1'b1);

        // Full-word write, AW and W together, then read back.
        do_write("w_deadbeef", 6'h08, 32'hDEAD_BEEF, 4'hF, 0, OKAY, 4'b0100);
        check("reg2_deadbeef", reg_slice(2), 32'hDEAD_BEEF);
        do_read("r_deadbeef", 6'h08, 32'hDEAD_BEEF, OKAY);

        // W two cycles ahead of AW, low half-word strobe over reset value 1.
        do_write("w_wfirst", 6'h04, 32'h1234_5678, 4'h3, 2, OKAY, 4'b0010);
        check("reg1_half", reg_slice(1), 32'h0000_5678);

        // Read-only register rejects writes and reads back the hardware value.
        do_write("w_ro", 6'h00, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, 4'b0000);
        check("reg_out_after_ro", reg_out, {32'h3, 32'hDEAD_BEEF, 32'h0000_5678, 32'h0});
        do_read("r_ro", 6'h00, 32'hCAFE_0000, OKAY);

        // Index 4 is beyond the register count.
        do_read("r_oor", 6'h10, 32'h0, SLVERR);
        do_write("w_oor", 6'h10, 32'h5555_5555, 4'hF, 0, SLVERR, 4'b0000);
        check("reg_out_after_oor", reg_out, {32'h3, 32'hDEAD_BEEF, 32'h0000_5678, 32'h0});

        // Zero strobe: pulses and answers OKAY but leaves the value alone.
        do_write("w_nostrb", 6'h0C, 32'hFFFF_FFFF, 4'h0, 0, OKAY, 4'b1000);
        check("reg3_nostrb", reg_slice(3), 32'h0000_0003);

        // Byte-offset address bits are ignored; top byte only.
        do_write("w_offset", 6'h0B, 32'hA500_0000, 4'b1000, 0, OKAY, 4'b0100);
        check("reg2_byte", reg_slice(2), 32'hA5AD_BEEF);
        do_read("r_offset", 6'h0A, 32'hA5AD_BEEF, OKAY);

        // Read handshake on the commit edge of the same register sees the old value.
        s_awvalid = 1'b1; s_awaddr = 6'h04; s_wvalid = 1'b1; s_wdata = 32'h0000_ABCD; s_wstrb = 4'hF;
        @(negedge s_aclk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_arvalid = 1'b1; s_araddr = 6'h04;
        @(negedge s_aclk);
        s_arvalid = 1'b0;
        check("conc_bvalid", s_bvalid, 1'b1);
        check("conc_rvalid", s_rvalid, 1'b1);
        check("conc_rdata_old", s_rdata, 32'h0000_5678);
        check("conc_reg1_new", reg_slice(1), 32'h0000_ABCD);
        check("conc_pulse", wr_pulse, 4'b0010);
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge s_aclk);
        s_bready = 1'b0; s_rready = 1'b0;
        check("conc_bvalid_done", s_bvalid, 1'b0);
        check("conc_rvalid_done", s_rvalid, 1'b0);
        $display("concurrent write/read addr=04 rdata=%08h", s_rdata);

        // Back-to-back reads with rready held high: one per two cycles.
        s_arvalid = 1'b1; s_araddr = 6'h04; s_rready = 1'b1;
        @(negedge s_aclk);
        check("b2b_rvalid0", s_rvalid, 1'b1);
        check("b2b_rdata0", s_rdata, 32'h0000_ABCD);
        check("b2b_arready_busy", s_arready, 1'b0);
        s_araddr = 6'h08;
        @(negedge s_aclk);
        check("b2b_gap", s_rvalid, 1'b0);
        check("b2b_arready_idle", s_arready, 1'b1);
        @(negedge s_aclk);
        s_arvalid = 1'b0;
        check("b2b_rvalid1", s_rvalid, 1'b1);
        check("b2b_rdata1", s_rdata, 32'hA5AD_BEEF);
        @(negedge s_aclk);
        s_rready = 1'b0;
        check("b2b_done", s_rvalid, 1'b0);
        $display("back-to-back reads addr=04,08");

        // Stall both responses, then reset in the middle of the wait.
        s_awvalid = 1'b1; s_awaddr = 6'h0C; s_wvalid = 1'b1; s_wdata = 32'h7777_7777; s_wstrb = 4'hF;
        s_arvalid = 1'b1; s_araddr = 6'h08;
        @(negedge s_aclk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge s_aclk);
        check("stall_pulse", wr_pulse, 4'b1000);
        s_awvalid = 1'b1; s_awaddr = 6'h04; s_wvalid = 1'b1; s_arvalid = 1'b1; s_araddr = 6'h04;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", s_bvalid, 1'b1);
            check("stall_bresp", s_bresp, OKAY);
            check("stall_rvalid", s_rvalid, 1'b1);
            check("stall_rdata", s_rdata, 32'hA5AD_BEEF);
            check("stall_rresp", s_rresp, OKAY);
            check("stall_awready", s_awready, 1'b0);
            check("stall_wready", s_wready, 1'b0);
            check("stall_arready", s_arready, 1'b0);
            check("stall_reg3", reg_slice(3), 32'h7777_7777);
            @(negedge s_aclk);
        end
        $display("stalled write addr=0C and read addr=08 for 5 cycles");
        s_aresetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        @(negedge s_aclk);
        s_aresetn = 1'b1;
        #1;
        check("rel2_awready", s_awready, 1'b0);
        @(negedge s_aclk);
        check("rel2_awready_live", s_awready, 1'b1);
        check("rel2_wready_live", s_wready, 1'b1);
        check("rel2_arready_live", s_arready, 1'b1);
        check("rel2_no_bvalid", s_bvalid, 1'b0);
        check("rel2_no_rvalid", s_rvalid, 1'b0);
        $display("reset during stall released");
        do_read("r_after_reset", 6'h0C, 32'h0000_0003, OKAY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_regfile.md
AXIL_REGFILE -- requirements
Module: axil_regfile

Interface
REQ-001 The block SHALL expose these parameters: C_S_AXI_DATA_WIDTH, 32, data bus width (32 or 64).
REQ-002 C_S_AXI_ADDR_WIDTH, 6, byte address width.
REQ-003 NUM_REGS, 16, register count (1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))).
REQ-004 RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from reg_in.
REQ-005 s_aclk  in  1  single clock; all logic on rising edge.
REQ-006 s_aresetn  in  1  reset, asynchronous, active-low.
REQ-007 s_awaddr/s_awprot/s_awvalid in, s_awready out  ADDR_WIDTH/3/1/1  write address channel (awprot ignored).
REQ-008 s_wdata/s_wstrb/s_wvalid in, s_wready out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
REQ-009 s_bresp/s_bvalid out, s_bready in  2/1/1  write response channel.
REQ-010 s_araddr/s_arprot/s_arvalid in, s_arready out  ADDR_WIDTH/3/1/1  read address channel (arprot ignored).
REQ-011 s_rdata/s_rresp/s_rvalid out, s_rready in  DATA_WIDTH/2/1/1  read data channel.
REQ-012 reg_in  in  NUM_REGS*DATA_WIDTH  hardware values for read-only registers, slice i = register i.
REQ-013 reg_out  out  NUM_REGS*DATA_WIDTH  current value of every writable register (RO slices drive 0).
REQ-014 wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle register i is updated by a write.

Function
REQ-015 Register index SHALL be addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low byte-offset bits ignored.
REQ-016 Write FSM states: W_IDLE, W_RESP; AW and W SHALL be accepted independently, in any order or the same cycle, each into its own holding register.
REQ-017 s_awready SHALL be high in W_IDLE while no address is held; s_wready high in W_IDLE while no data is held.
REQ-018 On the cycle both address and data are held, the write SHALL commit on the next edge, assert wr_pulse[i] for exactly that cycle, and enter W_RESP with s_bvalid=1.
REQ-019 Commit SHALL update only bytes whose s_wstrb bit is 1; wstrb=0 updates nothing but still pulses wr_pulse and responds OKAY.
REQ-020 Index >= NUM_REGS or RO_MASK[i]=1: no state change, no wr_pulse, s_bresp=SLVERR (2'b10); otherwise OKAY (2'b00).
REQ-021 s_bvalid and s_bresp SHALL hold stable until s_bready=1, then return to W_IDLE with holding registers cleared; no new AW/W accepted in W_RESP.
REQ-022 Read FSM states: R_IDLE, R_DATA; s_arready=1 only in R_IDLE; on AR handshake s_rdata SHALL be captured and s_rvalid=1 on the next cycle (latency 1).
REQ-023 Read data SHALL be reg_in slice for RO registers, stored value otherwise; index >= NUM_REGS returns 0 with SLVERR.
REQ-024 s_rvalid, s_rdata, s_rresp SHALL hold stable until s_rready=1, then return to R_IDLE.
REQ-025 Read and write channels SHALL operate concurrently; a read handshake on the same edge as a write commit to the same register returns the pre-write value.
REQ-026 Back-to-back: minimum write throughput one per 3 cycles, read one per 2 cycles with ready held high.

Reset
REQ-027 While s_aresetn=0, all of: awready, wready, arready=0; bvalid, rvalid=0; bresp, rresp, rdata=0; wr_pulse=0; both FSMs in IDLE; holding registers empty.
REQ-028 Writable register i SHALL reset to value i (register index), matching the existing bring-up pattern.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no register update and no response after release; ready signals go high on the first edge after release.

Structure
REQ-030 Package axil_regfile_pkg SHALL hold RESP_OKAY, RESP_SLVERR and the FSM state encodings.
REQ-031 Register storage with byte-strobe merge SHALL be one sub-module, axil_reg_bank; handshake FSMs stay in the top.

Verification
REQ-032 Write 0xDEADBEEF to 0x08 (AW and W same cycle), strobe 0xF -> BRESP OKAY, wr_pulse[2] one cycle, reg_out[2]=0xDEADBEEF, read 0x08 returns it.
REQ-033 W two cycles before AW to 0x04, wstrb=0x3, data 0x12345678 -> reg_out[1]=0x00005678.
REQ-034 RO_MASK=0x0001, reg_in[0]=0xCAFE0000, write 0x00 -> SLVERR, no wr_pulse; read 0x00 -> 0xCAFE0000 OKAY.
REQ-035 NUM_REGS=4, read 0x10 -> rdata 0, SLVERR; write 0x10 -> SLVERR, reg_out unchanged.
REQ-036 Hold s_bready=0 and s_rready=0 for 5 cycles -> bvalid/rvalid and payloads stable, no further ready asserted; assert s_aresetn=0 mid-wait -> all outputs reset per REQ-027/028.
